ss_scan_controller: RTL

//   Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS

---
 rtl/ss_scan_controller_if.sv | 13 +
 rtl/ss_scan_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ss_scan_controller_if.sv
// Load-side handshake bundle for the multiplexed 7-segment scan controller.
// The master supplies digit values and the blanking mode. The slave returns the display ack.
interface ss_scan_controller_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic                    load_ack;
    logic                    lz_blank_en;

    modport master (output bcd_in, output load, output lz_blank_en, input load_ack);
    modport slave  (input bcd_in, input load, input lz_blank_en, output load_ack);
endinterface

// File: rtl/ss_scan_controller.sv
// Round-robin common-anode digit scanner sharing one BCD-to-7-segment decoder.
// Display values are double-buffered and only swapped at a frame boundary.
module ss_scan_controller #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLANK_GAP  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ss_scan_controller_if.slave   bus,
    output logic [3:0]            dec_code,
    input  logic [6:0]            ss_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_done
);
    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]   GAP_LAST   = CW'(BLANK_GAP - 1);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

    typedef enum logic {S_GAP, S_DWELL} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [DW-1:0]          disp_q, disp_d;
    logic [DW-1:0]          pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  dig_en_q, dig_en_d;
    logic                   load_ack_q, load_ack_d;
    logic                   frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]  lead_zero;
    logic                   zeros_above;
    logic                   blank;
    logic                   last_idx;

    // lead_zero[i] is set when digit i and every more-significant digit are zero
    always_comb begin
        zeros_above = 1'b1;
        lead_zero   = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zeros_above = zeros_above && (disp_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            lead_zero[NUM_DIGITS-1-k] = zeros_above;
        end
    end

    assign blank    = bus.lz_blank_en && (idx_q != '0) && lead_zero[idx_q];
    assign last_idx = (idx_q == IDX_LAST);
    assign dec_code = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        seg_d        = seg_q;
        dig_en_d     = dig_en_q;
        load_ack_d   = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d           = '0;
                    state_d         = S_DWELL;
                    seg_d           = blank ? 7'h7F : ss_in;
                    dig_en_d        = '1;
                    dig_en_d[idx_q] = 1'b0;
                end
            end
            S_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_GAP;
                    seg_d    = 7'h7F;
                    dig_en_d = '1;
                    idx_d    = last_idx ? '0 : idx_q + 1'b1;
                    if (last_idx) begin
                        frame_done_d = 1'b1;
                        if (pend_valid_q) begin
                            disp_d       = pend_q;
                            pend_valid_d = 1'b0;
                            load_ack_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_GAP;
            end
        endcase

        // A load coinciding with the boundary refills pend after the old value moved to disp
        if (bus.load) begin
            pend_d       = bus.bcd_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'h7F;
            dig_en_q     <= '1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg          = seg_q;
    assign dig_en       = dig_en_q;
    assign frame_done   = frame_done_q;
    assign bus.load_ack = load_ack_q;
endmodule
